// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - shared constants, alarm state type and clock-divider helpers for timebase_timer
package timebase_pkg;

    localparam int US_PER_MS = 1000;
    localparam int HZ_PER_MHZ = 1_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } alarm_state_t;

    // Clocks per microsecond for a given system clock.
    function automatic int calc_div(input int clk_hz);
        return clk_hz / HZ_PER_MHZ;
    endfunction

    // A usable clock is a whole number of MHz, at least 1 MHz.
    function automatic bit clk_hz_ok(input int clk_hz);
        return (clk_hz >= HZ_PER_MHZ) && ((clk_hz % HZ_PER_MHZ) == 0);
    endfunction

endpackage

// File: rtl/timebase_tick_prescaler.sv
// rtl/timebase_tick_prescaler.sv - modulo-DIV event counter producing a registered one-cycle tick
module tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap,
    output logic tick_out
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // wrap marks the enabled event that completes a period; callers use it to
    // update state on the same edge that raises tick_out.
    assign wrap = en && (cnt == LAST);

    // Count enabled events 0..DIV-1; tick_out is high for the cycle after the last one.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt      <= '0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= wrap;
            if (en) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timebase_timer.sv
// rtl/timebase_timer.sv - us/ms timebase with one-shot/periodic alarm; TIMEBASE_SATURATE_EN makes the counters saturate
module timebase_timer
    import timebase_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] time_us,
    output logic [CNT_W-1:0] time_ms,
    output logic             us_tick,
    output logic             ms_tick,
    input  logic             alarm_start,
    input  logic [CNT_W-1:0] alarm_us,
    input  logic             alarm_periodic,
    input  logic             alarm_cancel,
    output logic             alarm_busy,
    output logic             alarm_done
);

    localparam int DIV = calc_div(CLK_HZ);

    generate
        if (!clk_hz_ok(CLK_HZ)) begin : g_bad_clk_hz
            $error("timebase_timer: CLK_HZ must be a whole number of MHz, at least 1 MHz");
        end
    endgenerate

    logic us_wrap;
    logic ms_wrap;

    alarm_state_t     state;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] reload;
    logic             periodic;

    tick_prescaler #(.DIV(DIV)) u_us_presc (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (1'b1),
        .wrap     (us_wrap),
        .tick_out (us_tick)
    );

    // Counts microseconds rather than clocks, so ms_tick lines up with us_tick.
    tick_prescaler #(.DIV(US_PER_MS)) u_ms_presc (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (us_wrap),
        .wrap     (ms_wrap),
        .tick_out (ms_tick)
    );

    // Free-running time counters, stepped on the edge that raises the matching tick.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            time_us <= '0;
            time_ms <= '0;
        end else begin
`ifdef TIMEBASE_SATURATE_EN
            if (us_wrap && (time_us != '1)) time_us <= time_us + 1'b1;
            if (ms_wrap && (time_ms != '1)) time_ms <= time_ms + 1'b1;
`else
            if (us_wrap) time_us <= time_us + 1'b1;
            if (ms_wrap) time_ms <= time_ms + 1'b1;
`endif
        end
    end

    // Alarm FSM: cancel beats start, start beats expiry; busy/done are registered.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= IDLE;
            remain     <= '0;
            reload     <= '0;
            periodic   <= 1'b0;
            alarm_busy <= 1'b0;
            alarm_done <= 1'b0;
        end else begin
            alarm_done <= 1'b0;
            if (alarm_cancel) begin
                state      <= IDLE;
                alarm_busy <= 1'b0;
            end else if (alarm_start) begin
                if (alarm_us != '0) begin
                    remain     <= alarm_us;
                    reload     <= alarm_us;
                    periodic   <= alarm_periodic;
                    state      <= RUN;
                    alarm_busy <= 1'b1;
                end else begin
                    state      <= IDLE;
                    alarm_busy <= 1'b0;
                    alarm_done <= 1'b1;
                end
            end else if ((state == RUN) && us_tick) begin
                if (remain == CNT_W'(1)) begin
                    alarm_done <= 1'b1;
                    if (periodic) begin
                        remain <= reload;
                    end else begin
                        state      <= IDLE;
                        alarm_busy <= 1'b0;
                    end
                end else begin
                    remain <= remain - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timebase_timer.sv
// tb/tb_timebase_timer.sv - directed scoreboard bench for timebase_timer
module tb_timebase_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        clr_w;
    logic        alarm_start;
    logic        alarm_periodic;
    logic        alarm_cancel;
    logic [31:0] alarm_us;

    logic [31:0] time_us, time_ms;
    logic        us_tick, ms_tick, alarm_busy, alarm_done;

    logic [3:0]  w_time_us, w_time_ms;
    logic        w_us_tick, w_ms_tick, w_busy, w_done;

    logic [15:0] o1_time_us, o1_time_ms;
    logic        o1_us_tick, o1_ms_tick, o1_busy, o1_done;

`ifdef TIMEBASE_SATURATE_EN
    localparam logic [3:0] W_AFTER_15 = 4'd15;
`else
    localparam logic [3:0] W_AFTER_15 = 4'd0;
`endif

    timebase_timer #(.CLK_HZ(4_000_000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .time_us(time_us), .time_ms(time_ms), .us_tick(us_tick), .ms_tick(ms_tick),
        .alarm_start(alarm_start), .alarm_us(alarm_us), .alarm_periodic(alarm_periodic),
        .alarm_cancel(alarm_cancel), .alarm_busy(alarm_busy), .alarm_done(alarm_done)
    );

    timebase_timer #(.CLK_HZ(4_000_000), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .clr(clr_w),
        .time_us(w_time_us), .time_ms(w_time_ms), .us_tick(w_us_tick), .ms_tick(w_ms_tick),
        .alarm_start(1'b0), .alarm_us(4'd0), .alarm_periodic(1'b0),
        .alarm_cancel(1'b0), .alarm_busy(w_busy), .alarm_done(w_done)
    );

    timebase_timer #(.CLK_HZ(1_000_000), .CNT_W(16)) dut_1 (
        .clk(clk), .rst(rst), .clr(clr),
        .time_us(o1_time_us), .time_ms(o1_time_ms), .us_tick(o1_us_tick), .ms_tick(o1_ms_tick),
        .alarm_start(1'b0), .alarm_us(16'd0), .alarm_periodic(1'b0),
        .alarm_cancel(1'b0), .alarm_busy(o1_busy), .alarm_done(o1_done)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    int     exp_q[$];

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        longint last;
        longint t0;
        longint dk;
        int     n;
        bit     seen;
        bit     busy_ok;
        logic [15:0] a1;
        logic [15:0] d1;

        rst = 1'b1; clr = 1'b0; clr_w = 1'b0;
        alarm_start = 1'b0; alarm_periodic = 1'b0; alarm_cancel = 1'b0; alarm_us = '0;

        // reset state
        @(negedge clk);
        step();
        step();
        chk("rst_time_us", time_us, 0);
        chk("rst_time_ms", time_ms, 0);
        chk("rst_us_tick", us_tick, 0);
        chk("rst_ms_tick", ms_tick, 0);
        chk("rst_busy", alarm_busy, 0);
        chk("rst_done", alarm_done, 0);
        rst = 1'b0;

        // us_tick cadence: one tick per 4 clocks, time_us 1,2,3...
        for (int i = 1; i <= 6; i++) exp_q.push_back(i);
        last = cyc;
        for (int i = 0; i < 24; i++) begin
            step();
            if (us_tick) begin
                chk("us_gap", cyc - last, 4);
                last = cyc;
                chk("us_time", time_us, exp_q.pop_front());
            end
        end
        chk("us_tick_count_left", exp_q.size(), 0);

        // millisecond rollover coincident with the 1000th us_tick
        exp_q.push_back(1000);
        seen = 1'b0;
        for (int i = 0; i < 4100 && !seen; i++) begin
            step();
            if (ms_tick) seen = 1'b1;
        end
        chk("ms_seen", seen, 1);
        chk("ms_with_us_tick", us_tick, 1);
        chk("ms_time_ms", time_ms, 1);
        chk("ms_time_us", time_us, exp_q.pop_front());
        step();
        chk("ms_tick_width", ms_tick, 0);

        // one-shot alarm of 5 us
        alarm_us = 5; alarm_periodic = 1'b0; alarm_start = 1'b1;
        step();
        alarm_start = 1'b0;
        t0 = cyc;
        chk("os_busy", alarm_busy, 1);
        exp_q.push_back(1);
        n = 0; dk = 0; busy_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (alarm_done) begin
                n++;
                if (n == 1) begin
                    dk = cyc - t0;
                    chk("os_busy_falls", alarm_busy, 0);
                end
            end else if (n == 0 && !alarm_busy) begin
                busy_ok = 1'b0;
            end
        end
        chk("os_busy_held", busy_ok, 1);
        chk("os_done_count", n, exp_q.pop_front());
        chk("os_done_window", (dk >= 17 && dk <= 20), 1);

        // periodic 3 us: pulses exactly 12 clocks apart
        alarm_us = 3; alarm_periodic = 1'b1; alarm_start = 1'b1;
        step();
        alarm_start = 1'b0;
        exp_q.push_back(12);
        exp_q.push_back(12);
        n = 0; last = 0;
        for (int i = 0; i < 80 && n < 3; i++) begin
            step();
            if (alarm_done) begin
                n++;
                if (n > 1) chk("per_gap", cyc - last, exp_q.pop_front());
                last = cyc;
            end
        end
        chk("per_pulses", n, 3);

        // cancel on the next expiry edge
        repeat (11) step();
        chk("per_pre_expiry_tick", us_tick, 1);
        alarm_cancel = 1'b1;
        step();
        alarm_cancel = 1'b0;
        alarm_periodic = 1'b0;
        chk("cancel_done", alarm_done, 0);
        chk("cancel_busy", alarm_busy, 0);
        n = 0;
        repeat (20) begin
            step();
            if (alarm_done) n++;
        end
        chk("cancel_quiet", n, 0);

        // cancel and start together: cancel wins
        alarm_us = 3; alarm_start = 1'b1; alarm_cancel = 1'b1;
        step();
        alarm_start = 1'b0; alarm_cancel = 1'b0;
        chk("cs_busy", alarm_busy, 0);
        chk("cs_done", alarm_done, 0);

        // zero interval: done next cycle, never busy
        alarm_us = 0; alarm_start = 1'b1;
        step();
        alarm_start = 1'b0;
        chk("zero_done", alarm_done, 1);
        chk("zero_busy", alarm_busy, 0);
        step();
        chk("zero_done_pulse", alarm_done, 0);
        chk("zero_busy_after", alarm_busy, 0);

        // start during RUN restarts the count
        alarm_us = 5; alarm_start = 1'b1;
        step();
        alarm_start = 1'b0;
        repeat (10) step();
        chk("rs_busy", alarm_busy, 1);
        alarm_start = 1'b1;
        step();
        alarm_start = 1'b0;
        t0 = cyc; n = 0; dk = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (alarm_done) begin
                n++;
                if (n == 1) dk = cyc - t0;
            end
        end
        chk("rs_count", n, 1);
        chk("rs_window", (dk >= 17 && dk <= 20), 1);

        // clr mid-alarm
        alarm_us = 5; alarm_start = 1'b1;
        step();
        alarm_start = 1'b0;
        repeat (8) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_time_us", time_us, 0);
        chk("clr_time_ms", time_ms, 0);
        chk("clr_busy", alarm_busy, 0);
        chk("clr_done", alarm_done, 0);
        n = 0;
        repeat (30) begin
            step();
            if (alarm_done) n++;
        end
        chk("clr_quiet", n, 0);
        chk("clr_restart_us", time_us, 7);

        // 4-bit counter at 15 us -> next tick wraps (or holds when saturating)
        clr_w = 1'b1;
        step();
        clr_w = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            if (w_time_us == 4'd15) seen = 1'b1;
        end
        chk("w_reach15", seen, 1);
        step();
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (w_us_tick) seen = 1'b1;
            else step();
        end
        chk("w_tick_seen", seen, 1);
        chk("w_after_15", w_time_us, W_AFTER_15);
        chk("w_time_ms", w_time_ms, 0);
        chk("w_ms_tick", w_ms_tick, 0);
        chk("w_busy", w_busy, 0);
        chk("w_done", w_done, 0);

        // DIV=1: us_tick constantly high, time_us steps every clock
        chk("d1_tick", o1_us_tick, 1);
        a1 = o1_time_us;
        step();
        d1 = o1_time_us - a1;
        chk("d1_inc", d1, 1);
        chk("d1_tick_again", o1_us_tick, 1);
        chk("d1_ms", o1_time_ms, o1_time_us / 16'd1000);
        chk("d1_ms_tick", o1_ms_tick, (o1_time_us % 16'd1000 == 0) && (o1_time_us != 0));
        chk("d1_busy", o1_busy, 0);
        chk("d1_done", o1_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timebase_timer.md
Name: timebase_timer

Overview:
- Parametrised successor to the single-output microsecond counter.
- Derives a 1 µs tick from the system clock via a prescaler, keeps free-running microsecond and millisecond counters of configurable width, and provides one programmable alarm (one-shot or periodic) with a start/done handshake.
- Serves as the shared timebase for game-flow delays, dealer pacing, input timeouts and RNG seeding.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; must be an integer multiple of 1_000_000 and at least 1_000_000.
- CNT_W, 32, width of time_us, time_ms and the alarm count.
- DIV (localparam), CLK_HZ/1_000_000, clocks per microsecond.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of the timebase and the alarm.
- time_us  out  CNT_W  microseconds since reset/clr.
- time_ms  out  CNT_W  milliseconds since reset/clr.
- us_tick  out  1  one-cycle pulse per microsecond.
- ms_tick  out  1  one-cycle pulse per millisecond.
- alarm_start  in  1  one-cycle request; latches alarm_us and alarm_periodic.
- alarm_us  in  CNT_W  alarm interval in microseconds.
- alarm_periodic  in  1  1 = reload the alarm after expiry; 0 = one-shot.
- alarm_cancel  in  1  stops the alarm without a done pulse.
- alarm_busy  out  1  alarm armed (state RUN).
- alarm_done  out  1  one-cycle pulse on expiry.

Behaviour:
- Reset (rst=1 at a clock edge): the prescaler, the ms sub-counter, time_us, time_ms, us_tick, ms_tick, alarm_done, alarm_busy and the alarm registers all go to 0; state goes to IDLE.
- Priority: rst > clr > alarm_cancel > alarm_start.
- Prescaler:
  - presc counts 0..DIV-1 and wraps.
  - us_tick is registered: it is high for the cycle after presc==DIV-1.
  - time_us increments in the same edge that raises us_tick.
  - DIV=1 gives us_tick constantly high.
- ms sub-counter:
  - sub counts us_ticks 0..999.
  - On the us_tick edge where sub==999: sub goes to 0, time_ms increments, and ms_tick is high for that cycle, coincident with us_tick.
- Wrap: time_us and time_ms wrap modulo 2^CNT_W (default build).
- clr: the same reset as rst, applied to the prescaler, sub, counters, ticks and alarm. clr is ignored while rst=1.
- Alarm FSM, states IDLE and RUN:
  - IDLE + start, alarm_us>0: load remain=alarm_us, store reload=alarm_us and the periodic flag; go to RUN; alarm_busy=1 from the next cycle.
  - IDLE + start, alarm_us==0: alarm_done pulses the next cycle; stay IDLE.
  - RUN: remain decrements on each us_tick.
  - RUN, remain==1 on a us_tick: alarm_done pulses the next cycle.
    - One-shot: go to IDLE (alarm_busy falls the same cycle alarm_done rises).
    - Periodic: remain=reload and stay in RUN, so the period is exactly reload microseconds.
  - RUN + start: restart with the new alarm_us and mode. A start on the expiry edge wins: no done pulse.
  - RUN + cancel: go to IDLE and drop alarm_busy next cycle; no done pulse, even on the expiry edge.
  - Cancel + start in the same cycle: cancel wins.
- The first expiry falls between alarm_us-1 and alarm_us µs after start, because the prescaler phase is not reset by start.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: TIMEBASE_SATURATE_EN.
- Defined: time_us and time_ms hold at all-ones instead of wrapping. Ticks and the alarm continue normally.
- Undefined: both counters wrap to 0.

Decomposition:
- Package timebase_pkg holds:
  - the US_PER_MS=1000 constant;
  - the alarm state enum (IDLE, RUN);
  - a function computing DIV with an elaboration check that CLK_HZ is a multiple of 1_000_000.
- One natural sub-module, tick_prescaler: parameter DIV; ports clk, rst, clr, tick_out. It is instantiated twice: as DIV for us_tick and as 1000 gated by us_tick for ms_tick.

Test Plan:
- Reset/tick cadence, CLK_HZ=4_000_000: rst high 2 cycles then low → us_tick once every 4 cycles, time_us=1,2,3…, all outputs 0 during reset.
- ms rollover: run 4000 cycles → ms_tick coincides with the 1000th us_tick, time_ms=1, time_us=1000.
- One-shot alarm: start with alarm_us=5 → alarm_busy high for the interval, exactly one alarm_done 17–20 clocks after start, busy falls with done.
- Periodic + cancel: alarm_us=3, periodic=1 → done pulses spaced exactly 12 cycles apart; cancel on the expiry edge → no pulse, busy low next cycle.
- Boundaries: alarm_us=0 → done the next cycle with busy never set. Start during RUN restarts the count. clr mid-alarm zeroes the counters and busy with no done.
- Wrap, CNT_W=4: run past 15 µs → time_us 15→0. With TIMEBASE_SATURATE_EN defined → holds at 15.
